// File: rtl/bus_pkg.sv
// Shared definitions for the serial system-bus master port:
// state encoding, mode constants and width helpers.
package bus_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_REQ      = 4'd1;
  localparam logic [3:0] ST_ADDR_DEV = 4'd2;
  localparam logic [3:0] ST_WAIT_ACK = 4'd3;
  localparam logic [3:0] ST_ADDR_MEM = 4'd4;
  localparam logic [3:0] ST_WDATA    = 4'd5;
  localparam logic [3:0] ST_RDATA    = 4'd6;
  localparam logic [3:0] ST_DONE     = 4'd7;
  localparam logic [3:0] ST_ABORT    = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    REQ      = ST_REQ,
    ADDR_DEV = ST_ADDR_DEV,
    WAIT_ACK = ST_WAIT_ACK,
    ADDR_MEM = ST_ADDR_MEM,
    WDATA    = ST_WDATA,
    RDATA    = ST_RDATA,
    DONE     = ST_DONE,
    ABORT    = ST_ABORT
  } state_t;

  // Which latched field the serialiser presents on the bus
  typedef enum logic [1:0] {
    FLD_DEV,
    FLD_MEM,
    FLD_DATA
  } field_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int dev_w(
    input int aw,
    input int mw
  );
    return aw - mw;
  endfunction

  function automatic int cnt_w(
    input int mw,
    input int dw
  );
    return $clog2((mw > dw) ? mw : dw) + 1;
  endfunction

endpackage

// File: rtl/piso_sipo_shift.sv
// Request latch, serialiser bit select, read deserialiser
// and the shared bit counter for the bus master port.
module piso_sipo_shift
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int CW                   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  cnt_clr,
  input  logic                  cnt_inc,
  input  logic                  shift_en,
  input  logic                  sin,
  input  field_t                fld,
  input  logic [CW-1:0]         idx,
  output logic [CW-1:0]         cnt,
  output logic                  sbit,
  output logic [DATA_WIDTH-1:0] rd_word
);

  localparam int AIW = $clog2(ADDR_WIDTH);
  localparam int DIW = $clog2(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [AIW-1:0]        ai;
  logic [DIW-1:0]        di;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (load) begin
      addr_q <= addr_in;
      data_q <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // First received bit ends up in the LSB after a full word
  assign rd_word = {sin, sr_q[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (shift_en) begin
      sr_q <= rd_word;
    end
  end

  always_comb begin
    ai   = '0;
    di   = '0;
    sbit = 1'b0;
    unique case (fld)
      FLD_DEV: begin
        ai   = AIW'(SLAVE_MEM_ADDR_WIDTH) + AIW'(idx);
        sbit = addr_q[ai];
      end
      FLD_MEM: begin
        ai   = AIW'(idx);
        sbit = addr_q[ai];
      end
      FLD_DATA: begin
        di   = DIW'(idx);
        sbit = data_q[di];
      end
      default: sbit = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_master_port.sv
// Master port: turns a parallel device request into the
// serial bit protocol of the shared system bus and back.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int ACK_TIMEOUT          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  dready,
  output logic                  derror,
  output logic                  dbusy,
  output logic                  breq,
  input  logic                  bgrant,
  output logic                  wdata,
  output logic                  mode,
  output logic                  mvalid,
  input  logic                  ack,
  input  logic                  rdata,
  input  logic                  svalid
);

  localparam int DEV_W =
    dev_w(ADDR_WIDTH, SLAVE_MEM_ADDR_WIDTH);
  localparam int CW =
    cnt_w(SLAVE_MEM_ADDR_WIDTH, DATA_WIDTH);

  localparam logic [CW-1:0] DEV_LAST  = CW'(DEV_W - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] MEM_LAST  =
    CW'(SLAVE_MEM_ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  state_t                st;
  state_t                nxt;
  field_t                fld;
  logic                  mode_q;
  logic                  mvalid_q;
  logic                  load;
  logic                  cnt_clr;
  logic                  cnt_inc;
  logic                  shift_en;
  logic                  sbit;
  logic                  on_bus;
  logic                  drive;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      mode_q <= MODE_READ;
    end else begin
      st <= nxt;
      if (load) begin
        mode_q <= dmode;
      end
    end
  end

  // Grant loss wins over every other event in the bus phases
  always_comb begin
    nxt      = st;
    load     = 1'b0;
    cnt_inc  = 1'b0;
    shift_en = 1'b0;
    unique case (st)
      IDLE: begin
        if (dvalid) begin
          nxt  = REQ;
          load = 1'b1;
        end
      end
      REQ: begin
        if (bgrant) nxt = ADDR_DEV;
      end
      ADDR_DEV: begin
        if (!bgrant) nxt = ABORT;
        else if (cnt == DEV_LAST) nxt = WAIT_ACK;
        else cnt_inc = 1'b1;
      end
      WAIT_ACK: begin
        if (!bgrant) nxt = ABORT;
        else if (ack) nxt = ADDR_MEM;
        else if (cnt == ACK_LAST) nxt = ABORT;
        else cnt_inc = 1'b1;
      end
      ADDR_MEM: begin
        if (!bgrant) begin
          nxt = ABORT;
        end else if (cnt == MEM_LAST) begin
          nxt = (mode_q == MODE_WRITE) ? WDATA : RDATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WDATA: begin
        if (!bgrant) nxt = ABORT;
        else if (cnt == DATA_LAST) nxt = DONE;
        else cnt_inc = 1'b1;
      end
      RDATA: begin
        if (!bgrant) begin
          nxt = ABORT;
        end else if (svalid) begin
          shift_en = 1'b1;
          if (cnt == DATA_LAST) nxt = DONE;
          else cnt_inc = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      ABORT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cnt_clr = (nxt != st);
  end

  always_comb begin
    fld = FLD_DEV;
    unique case (nxt)
      ADDR_MEM: fld = FLD_MEM;
      WDATA:    fld = FLD_DATA;
      default:  fld = FLD_DEV;
    endcase
  end

  assign cnt_nxt = cnt_clr ? '0 :
                   cnt_inc ? cnt + CW'(1) : cnt;

  assign on_bus = nxt inside
    {ADDR_DEV, WAIT_ACK, ADDR_MEM, WDATA, RDATA};
  assign drive  = nxt inside {ADDR_DEV, ADDR_MEM, WDATA};

  // Outputs are registered from next-state so they line up with st
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breq     <= 1'b0;
      dbusy    <= 1'b0;
      dready   <= 1'b0;
      derror   <= 1'b0;
      mode     <= MODE_READ;
      mvalid_q <= 1'b0;
      wdata    <= 1'b0;
      drdata   <= '0;
    end else begin
      breq     <= (nxt == REQ) || on_bus;
      dbusy    <= (nxt != IDLE);
      dready   <= (nxt == DONE);
      derror   <= (nxt == ABORT);
      mode     <= (nxt == IDLE || nxt == REQ) ?
                  MODE_READ : mode_q;
      mvalid_q <= drive;
      wdata    <= drive & sbit;
      if (shift_en && nxt == DONE) begin
        drdata <= rd_word;
      end
    end
  end

  // A dropped grant silences the bus in the same cycle
  assign mvalid = mvalid_q & bgrant;

  piso_sipo_shift #(
    .ADDR_WIDTH           (ADDR_WIDTH),
    .DATA_WIDTH           (DATA_WIDTH),
    .SLAVE_MEM_ADDR_WIDTH (SLAVE_MEM_ADDR_WIDTH),
    .CW                   (CW)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .addr_in  (daddr),
    .data_in  (dwdata),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .shift_en (shift_en),
    .sin      (rdata),
    .fld      (fld),
    .idx      (cnt_nxt),
    .cnt      (cnt),
    .sbit     (sbit),
    .rd_word  (rd_word)
  );

endmodule

// File: tb/tb_bus_master_port.sv
// Randomised bench for bus_master_port: plays arbiter,
// decoder and slave, checks against a transaction-level model.
module tb_bus_master_port;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int MW    = 12;
  localparam int AT    = 4;
  localparam int DEV_W = AW - MW;

  logic          clk = 1'b0;
  logic          rst;
  logic          dvalid;
  logic          dmode;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] drdata;
  logic          dready;
  logic          derror;
  logic          dbusy;
  logic          breq;
  logic          bgrant;
  logic          wdata;
  logic          mode;
  logic          mvalid;
  logic          ack;
  logic          rdata;
  logic          svalid;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] prev_rd;
  logic [AW-1:0] nxt_a;
  logic [DW-1:0] nxt_d;
  logic          nxt_m;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_WIDTH           (AW),
    .DATA_WIDTH           (DW),
    .SLAVE_MEM_ADDR_WIDTH (MW),
    .ACK_TIMEOUT          (AT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dvalid (dvalid),
    .dmode  (dmode),
    .daddr  (daddr),
    .dwdata (dwdata),
    .drdata (drdata),
    .dready (dready),
    .derror (derror),
    .dbusy  (dbusy),
    .breq   (breq),
    .bgrant (bgrant),
    .wdata  (wdata),
    .mode   (mode),
    .mvalid (mvalid),
    .ack    (ack),
    .rdata  (rdata),
    .svalid (svalid)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic env_idle();
    dvalid = 1'b0;
    bgrant = 1'b0;
    ack    = 1'b0;
    svalid = 1'b0;
    rdata  = 1'b0;
  endtask

  // One transaction; the bench acts as arbiter/decoder/slave.
  // ackw: WAIT_ACK cycle carrying ack (0 = never).
  // drop: bits seen on the bus before the grant is pulled.
  // rstat: bits seen before an asynchronous reset.
  task automatic run_txn(
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic          m,
    input logic [DW-1:0] rdv,
    input int            gdel,
    input int            ackw,
    input int            gaps,
    input int            drop,
    input int            rstat,
    input bit            hold,
    input bit            skip
  );
    bit q[$];
    int bits = 0, req_obs = 0, wait_drv = 0;
    int wait_obs = 0, rd_idx = 0, gap_c = 0;
    int cyc = 0, g_cyc = 0, d_cyc = 0;
    int nrdy = 0, nerr = 0, exp_n = 0, b0;
    bit granted = 0, dropped = 0, acked = 0;
    bit done = 0, chk_drop = 0, was_rst = 0;
    bit ok = 0, tmo = 0, tmo_ab = 0, breq_last = 0;

    for (int i = 0; i < DEV_W; i++) q.push_back(a[MW+i]);
    for (int i = 0; i < MW; i++) q.push_back(a[i]);
    if (m) for (int i = 0; i < DW; i++) q.push_back(d[i]);

    tmo = (ackw == 0) || (ackw > AT);
    if (drop >= 0 && drop <= DEV_W) begin
      exp_n = drop;
    end else if (tmo) begin
      exp_n  = DEV_W;
      tmo_ab = 1;
    end else if (drop >= 0) begin
      exp_n = drop;
    end else begin
      ok    = 1;
      exp_n = DEV_W + MW + (m ? DW : 0);
    end

    if (skip) begin
      req_obs   = 1;
      breq_last = 1;
    end else begin
      @(posedge clk); #1;
      daddr  = a;
      dwdata = d;
      dmode  = m;
      dvalid = 1'b1;
      @(negedge clk);
    end

    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (hold) begin
        daddr  = nxt_a;
        dwdata = nxt_d;
        dmode  = nxt_m;
        dvalid = 1'b1;
      end else begin
        dvalid = 1'b0;
      end
      if (!breq_last || dropped) begin
        bgrant = 1'b0;
      end else if (drop >= 0 && bits == drop && granted) begin
        bgrant   = 1'b0;
        dropped  = 1;
        chk_drop = 1;
      end else if (granted || req_obs > gdel) begin
        bgrant = 1'b1;
        if (!granted) begin
          granted = 1;
          g_cyc   = cyc;
        end
      end else begin
        bgrant = 1'b0;
      end
      ack = 1'b0;
      if (bits == DEV_W && !acked && breq_last) begin
        wait_drv++;
        if (wait_drv == ackw) begin
          ack   = 1'b1;
          acked = 1;
        end
      end
      svalid = 1'b0;
      rdata  = 1'b0;
      if (!m && bits == DEV_W + MW && breq_last &&
          rd_idx < DW) begin
        if (gap_c < gaps) begin
          gap_c++;
        end else begin
          svalid = 1'b1;
          rdata  = rdv[rd_idx];
          rd_idx++;
          gap_c  = 0;
        end
      end

      @(negedge clk);
      b0 = bits;
      if (chk_drop) begin
        check("drop_mvalid", mvalid, 0);
        chk_drop = 0;
      end
      if (!m && b0 == DEV_W + MW && breq)
        check("rd_mvalid", mvalid, 0);
      if (b0 == DEV_W && breq && !mvalid) wait_obs++;
      if (mvalid) begin
        if (q.size() > 0) check("bus_bit", wdata, q.pop_front());
        else check("extra_bit", mvalid, 0);
        check("bus_mode", mode, m);
        bits++;
      end
      if (breq && !granted) req_obs++;
      if (dready) begin
        nrdy++;
        d_cyc = cyc;
        check("rdy_breq", breq, 0);
        done = 1;
      end
      if (derror) begin
        nerr++;
        check("err_breq", breq, 0);
        done = 1;
      end
      breq_last = breq;
      if (rstat >= 0 && bits == rstat && !done) begin
        #2 rst = 1'b1;
        #1;
        check("arst_breq", breq, 0);
        check("arst_mvalid", mvalid, 0);
        check("arst_wdata", wdata, 0);
        check("arst_mode", mode, 0);
        check("arst_dbusy", dbusy, 0);
        check("arst_drdata", drdata, 0);
        env_idle();
        @(posedge clk); #1;
        rst     = 1'b0;
        prev_rd = '0;
        was_rst = 1;
        done    = 1;
      end
    end

    check("cycle_budget", done, 1);
    if (was_rst) begin
      repeat (3) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_busy", dbusy, 0);
        check("post_rst_rdy", dready, 0);
        check("post_rst_err", derror, 0);
      end
      return;
    end

    check("n_ready", nrdy, 32'(ok));
    check("n_error", nerr, 32'(!ok));
    check("n_bits", bits, exp_n);
    check("drdata", drdata, (ok && !m) ? rdv : prev_rd);
    if (ok && !m) prev_rd = rdv;
    if (tmo_ab) check("ack_wait", wait_obs, AT);
    if (ok) check("ack_wait", wait_obs, ackw);
    if (ok && m)
      check("wr_latency", d_cyc - g_cyc,
            DEV_W + ackw + MW + DW + 1);
    if (!hold) begin
      @(posedge clk); #1;
      env_idle();
      @(negedge clk);
      check("end_busy", dbusy, 0);
      check("end_rdy", dready, 0);
      check("end_err", derror, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [DW-1:0] rr;
    logic          rm;
    int            rdrop;

    rst     = 1'b1;
    dmode   = 1'b0;
    daddr   = '0;
    dwdata  = '0;
    prev_rd = '0;
    env_idle();
    #12;
    check("rst_breq", breq, 0);
    check("rst_mvalid", mvalid, 0);
    check("rst_wdata", wdata, 0);
    check("rst_mode", mode, 0);
    check("rst_dready", dready, 0);
    check("rst_derror", derror, 0);
    check("rst_dbusy", dbusy, 0);
    check("rst_drdata", drdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // write 0x1234 <- 0xA5, slow grant, immediate ack
    run_txn(16'h1234, 8'hA5, 1'b1, 8'h00,
            2, 1, 0, -1, -1, 0, 0);
    // read 0x2010 -> 0x3C with svalid gaps
    run_txn(16'h2010, 8'h00, 1'b0, 8'h3C,
            0, 2, 2, -1, -1, 0, 0);
    // no ack at all
    run_txn(16'h5ABC, 8'h11, 1'b1, 8'h00,
            1, 0, 0, -1, -1, 0, 0);
    // grant pulled during write data bit 3
    run_txn(16'h7F0E, 8'hC3, 1'b1, 8'h00,
            0, 1, 0, DEV_W + MW + 3, -1, 0, 0);
    // async reset in the memory-address phase
    run_txn(16'h4567, 8'h89, 1'b1, 8'h00,
            0, 1, 0, -1, DEV_W + 5, 0, 0);
    run_txn(16'h3FFF, 8'hFF, 1'b1, 8'h00,
            1, 3, 0, -1, -1, 0, 0);

    // back-to-back: dvalid held through dready
    nxt_a = 16'hB2C4;
    nxt_d = 8'h5E;
    nxt_m = 1'b1;
    run_txn(16'h1F00, 8'h00, 1'b0, 8'h96,
            0, 1, 1, -1, -1, 1, 0);
    @(posedge clk); #1;
    bgrant = 1'b0;
    ack    = 1'b0;
    svalid = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", dbusy, 0);
    check("b2b_idle_rdy", dready, 0);
    @(posedge clk); #1;
    dvalid = 1'b0;
    @(negedge clk);
    check("b2b_req", breq, 1);
    check("b2b_busy", dbusy, 1);
    run_txn(nxt_a, nxt_d, nxt_m, 8'h00,
            0, 1, 0, -1, -1, 0, 1);

    for (int t = 0; t < 30; t++) begin
      ra = AW'($urandom);
      rd = DW'($urandom);
      rr = DW'($urandom);
      rm = 1'($urandom);
      rdrop = -1;
      if ($urandom_range(0, 3) == 0)
        rdrop = int'($urandom_range(0, rm ? 23 : 16));
      run_txn(ra, rd, rm, rr,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)),
              rdrop, -1, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
